// File: rtl/dct_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dct_pkg
// Brief    : Shared constants and helper functions for the 8-point 1D DCT.
// Revision : 1.0 - initial release
// ============================================================================
package dct_pkg;

    // DCT cosine coefficients, scaled by 2^7
    localparam int C1 = 64;
    localparam int C2 = 60;
    localparam int C3 = 56;
    localparam int C4 = 45;
    localparam int C5 = 36;
    localparam int C6 = 24;
    localparam int C7 = 12;

    function automatic int acc_width(input int in_w);
        return in_w + 11;
    endfunction

    function automatic int lane_lo(input int lane, input int w);
        return lane * w;
    endfunction

    // Coefficient of product j feeding output k (j = 0 in the low byte)
    function automatic int mac_coef(input int k, input int j);
        logic [31:0] row;
        case (k)
            0, 4:    row = {8'(C4), 8'(C4), 8'(C4), 8'(C4)};
            1:       row = {8'(C7), 8'(C5), 8'(C3), 8'(C1)};
            2:       row = {8'd0,   8'd0,   8'(C6), 8'(C2)};
            3:       row = {8'(C5), 8'(C1), 8'(C7), 8'(C3)};
            5:       row = {8'(C3), 8'(C7), 8'(C1), 8'(C5)};
            6:       row = {8'd0,   8'd0,   8'(C2), 8'(C6)};
            default: row = {8'(C1), 8'(C3), 8'(C5), 8'(C7)};
        endcase
        return int'(row[j*8 +: 8]);
    endfunction

    // Term index: 0..3 = s0..s3, 4..7 = d0..d3, 8 = s0-s3, 9 = s1-s2
    function automatic int mac_term(input int k, input int j);
        case (k)
            0, 4:    return j;
            2, 6:    return 8 + (j & 1);
            default: return 4 + j;
        endcase
    endfunction

    function automatic logic mac_neg(input int k, input int j);
        logic [3:0] m;
        case (k)
            3:       m = 4'b1110;
            4:       m = 4'b0110;
            5, 6:    m = 4'b0010;
            7:       m = 4'b1010;
            default: m = 4'b0000;
        endcase
        return m[j];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dct_approx_mult.sv
`default_nettype none
// ============================================================================
// Module   : dct_approx_mult
// Brief    : Signed constant multiply with optional floor to 2^APPROX_BITS.
// Revision : 1.0 - initial release
// ============================================================================
module dct_approx_mult #(
    parameter int TERM_W      = 10,
    parameter int PROD_W      = 18,
    parameter int COEF        = 64,
    parameter int APPROX_BITS = 6
) (
    input  logic signed [TERM_W-1:0] term,
    input  logic                     approx,
    output logic signed [PROD_W-1:0] prod
);

    localparam logic signed [PROD_W-1:0] c_coef = PROD_W'(COEF);
    localparam logic signed [PROD_W-1:0] c_keep = ~PROD_W'((1 << APPROX_BITS) - 1);

    logic signed [PROD_W-1:0] w_ext;
    logic signed [PROD_W-1:0] w_full;

    assign w_ext  = PROD_W'(term);
    assign w_full = w_ext * c_coef;
    // Masking low bits of a two's-complement value floors toward -inf
    assign prod   = approx ? (w_full & c_keep) : w_full;

endmodule
`default_nettype wire

// File: rtl/dct_1d_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dct_1d_pipe
// Brief    : 3-stage 8-point forward DCT with valid/ready, rounding, clamping.
// Revision : 1.0 - initial release
// ============================================================================
module dct_1d_pipe
    import dct_pkg::*;
#(
    parameter int IN_W        = 8,
    parameter int OUT_W       = IN_W + 2,
    parameter int SHIFT       = 7,
    parameter int APPROX_BITS = 6,
    parameter int ROUND       = 1,
    parameter int BLOCK_LEN   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*IN_W-1:0]    in_data,
    input  logic                 approx_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*OUT_W-1:0]   out_data,
    output logic                 out_last,
    output logic                 out_sat
);

    localparam int c_term_w = IN_W + 2;
    localparam int c_prod_w = c_term_w + 8;
    localparam int c_acc_w  = acc_width(IN_W);
    localparam int c_rnd_w  = c_acc_w + 1;
    localparam int c_cnt_w  = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;

    localparam logic signed [c_rnd_w-1:0] c_round =
        (ROUND != 0 && SHIFT > 0) ? c_rnd_w'(1 << (SHIFT - 1)) : '0;
    localparam logic signed [c_rnd_w-1:0] c_sat_max = c_rnd_w'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [c_rnd_w-1:0] c_sat_min = ~c_sat_max;
    localparam logic [c_cnt_w-1:0]        c_cnt_end = c_cnt_w'(BLOCK_LEN - 1);

    logic                        w_adv;
    logic signed [IN_W-1:0]      w_x    [8];
    logic signed [IN_W:0]        r_s    [4];
    logic signed [IN_W:0]        r_d    [4];
    logic                        r_s1_valid;
    logic                        r_s1_approx;
    logic signed [c_term_w-1:0]  w_term [10];
    logic signed [c_prod_w-1:0]  w_prod [8][4];
    logic signed [c_acc_w-1:0]   w_ext;
    logic signed [c_acc_w-1:0]   w_acc  [8];
    logic signed [c_acc_w-1:0]   r_acc  [8];
    logic                        r_s2_valid;
    logic signed [c_rnd_w-1:0]   w_rnd;
    logic signed [OUT_W-1:0]     w_lane [8];
    logic                        w_sat;
    logic                        r_out_valid;
    logic [8*OUT_W-1:0]          r_out_data;
    logic                        r_out_sat;
    logic [c_cnt_w-1:0]          r_count;

    // Every stage moves together, so bubbles are preserved
    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv && rst;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_x[i] = in_data[lane_lo(i, IN_W) +: IN_W];
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_term[i]     = c_term_w'(r_s[i]);
            w_term[4 + i] = c_term_w'(r_d[i]);
        end
        w_term[8] = c_term_w'(r_s[0]) - c_term_w'(r_s[3]);
        w_term[9] = c_term_w'(r_s[1]) - c_term_w'(r_s[2]);
    end

    for (genvar k = 0; k < 8; k++) begin : g_coef
        for (genvar j = 0; j < 4; j++) begin : g_prod
            dct_approx_mult #(
                .TERM_W      (c_term_w),
                .PROD_W      (c_prod_w),
                .COEF        (mac_coef(k, j)),
                .APPROX_BITS (APPROX_BITS)
            ) u_mult (
                .term   (w_term[mac_term(k, j)]),
                .approx (r_s1_approx),
                .prod   (w_prod[k][j])
            );
        end
    end

    always_comb begin
        w_ext = '0;
        for (int k = 0; k < 8; k++) begin
            w_acc[k] = '0;
            for (int j = 0; j < 4; j++) begin
                w_ext    = c_acc_w'(w_prod[k][j]);
                w_acc[k] = mac_neg(k, j) ? (w_acc[k] - w_ext) : (w_acc[k] + w_ext);
            end
        end
    end

    // One extra bit keeps the rounding add from wrapping before the shift
    always_comb begin
        w_rnd = '0;
        w_sat = 1'b0;
        for (int k = 0; k < 8; k++) begin
            w_rnd = (c_rnd_w'(r_acc[k]) + c_round) >>> SHIFT;
            if (w_rnd > c_sat_max) begin
                w_lane[k] = c_sat_max[OUT_W-1:0];
                w_sat     = 1'b1;
            end else if (w_rnd < c_sat_min) begin
                w_lane[k] = c_sat_min[OUT_W-1:0];
                w_sat     = 1'b1;
            end else begin
                w_lane[k] = w_rnd[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_approx <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            r_count     <= '0;
            for (int i = 0; i < 4; i++) begin
                r_s[i] <= '0;
                r_d[i] <= '0;
            end
            for (int k = 0; k < 8; k++) begin
                r_acc[k] <= '0;
            end
        end else begin
            if (w_adv) begin
                r_s1_valid  <= in_valid;
                r_s1_approx <= approx_en;
                for (int i = 0; i < 4; i++) begin
                    r_s[i] <= (IN_W + 1)'(w_x[i]) + (IN_W + 1)'(w_x[7 - i]);
                    r_d[i] <= (IN_W + 1)'(w_x[i]) - (IN_W + 1)'(w_x[7 - i]);
                end
                r_s2_valid <= r_s1_valid;
                for (int k = 0; k < 8; k++) begin
                    r_acc[k] <= w_acc[k];
                end
                r_out_valid <= r_s2_valid;
                if (r_s2_valid) begin
                    for (int k = 0; k < 8; k++) begin
                        r_out_data[lane_lo(k, OUT_W) +: OUT_W] <= w_lane[k];
                    end
                    r_out_sat <= w_sat;
                end
            end
            if (r_out_valid && out_ready) begin
                r_count <= (r_count == c_cnt_end) ? '0 : r_count + c_cnt_w'(1);
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign out_last  = r_out_valid && (r_count == c_cnt_end);

endmodule
`default_nettype wire

// File: tb/tb_dct_1d_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_dct_1d_pipe
// Brief    : Self-checking bench for dct_1d_pipe (SHIFT=7 and SHIFT=4 copies).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dct_1d_pipe;

    localparam int AB = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        approx_en = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, out_last_a, out_sat_a;
    logic [79:0] out_data_a;
    logic        in_ready_b, out_valid_b, out_last_b, out_sat_b;
    logic [79:0] out_data_b;

    always #5 clk = ~clk;

    dct_1d_pipe u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .approx_en(approx_en), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data(out_data_a), .out_last(out_last_a),
        .out_sat(out_sat_a)
    );

    dct_1d_pipe #(.SHIFT(4)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .approx_en(approx_en), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_data_b), .out_last(out_last_b),
        .out_sat(out_sat_b)
    );

    typedef struct {
        logic [79:0] d7;
        logic        s7;
        logic [79:0] d4;
        logic        s4;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          out_cnt = 0;
    int          lasts = 0;
    bit          drv_rst = 0, drv_valid = 0, drv_approx = 0, drv_ready = 1;
    logic [63:0] drv_data = '0;
    bit          held = 0, last_acc = 0;
    logic [79:0] held_data = '0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int q(input int p, input bit ap);
        return ap ? p - (p & ((1 << AB) - 1)) : p;
    endfunction

    function automatic int lane(input logic [79:0] v, input int k);
        logic signed [9:0] t;
        t = v[k*10 +: 10];
        return int'(t);
    endfunction

    // Direct evaluation of the DCT equations in integer arithmetic
    function automatic void model(input logic [63:0] din, input bit ap, input int sh,
                                  output logic [79:0] dout, output logic sat);
        int x[8]; int s[4]; int d[4]; int X[8]; int v;
        for (int i = 0; i < 8; i++) x[i] = $signed(din[i*8 +: 8]);
        for (int i = 0; i < 4; i++) begin
            s[i] = x[i] + x[7-i];
            d[i] = x[i] - x[7-i];
        end
        X[0] = q(45*s[0], ap) + q(45*s[1], ap) + q(45*s[2], ap) + q(45*s[3], ap);
        X[4] = q(45*s[0], ap) - q(45*s[1], ap) - q(45*s[2], ap) + q(45*s[3], ap);
        X[2] = q(60*(s[0]-s[3]), ap) + q(24*(s[1]-s[2]), ap);
        X[6] = q(24*(s[0]-s[3]), ap) - q(60*(s[1]-s[2]), ap);
        X[1] = q(64*d[0], ap) + q(56*d[1], ap) + q(36*d[2], ap) + q(12*d[3], ap);
        X[3] = q(56*d[0], ap) - q(12*d[1], ap) - q(64*d[2], ap) - q(36*d[3], ap);
        X[5] = q(36*d[0], ap) - q(64*d[1], ap) + q(12*d[2], ap) + q(56*d[3], ap);
        X[7] = q(12*d[0], ap) - q(36*d[1], ap) + q(56*d[2], ap) - q(64*d[3], ap);
        sat  = 1'b0;
        dout = '0;
        for (int k = 0; k < 8; k++) begin
            v = (X[k] + (1 << (sh - 1))) >>> sh;
            if (v > 511) begin v = 511; sat = 1'b1; end
            else if (v < -512) begin v = -512; sat = 1'b1; end
            dout[k*10 +: 10] = v[9:0];
        end
    endfunction

    task automatic cycle();
        exp_t e;
        bit   exp_ready;
        @(negedge clk);
        rst       = drv_rst;
        in_valid  = drv_valid;
        in_data   = drv_data;
        approx_en = drv_approx;
        out_ready = drv_ready;
        #1;
        exp_ready = drv_rst && (!out_valid_a || drv_ready);
        chk("in_ready_a", in_ready_a, exp_ready);
        chk("in_ready_b", in_ready_b, exp_ready);
        chk("valid_b_vs_a", out_valid_b, out_valid_a);
        last_acc = drv_valid && exp_ready;
        if (!drv_rst) begin
            exp_q.delete();
            out_cnt = 0;
            held    = 0;
        end else begin
            if (held) chk("hold_data", out_data_a, held_data);
            if (out_valid_a) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", out_valid_a, 1'b0);
                end else begin
                    e = exp_q[0];
                    chk("data_sh7", out_data_a, e.d7);
                    chk("sat_sh7", out_sat_a, e.s7);
                    chk("data_sh4", out_data_b, e.d4);
                    chk("sat_sh4", out_sat_b, e.s4);
                    chk("last_a", out_last_a, (out_cnt % 8) == 7);
                    chk("last_b", out_last_b, (out_cnt % 8) == 7);
                    if (drv_ready) begin
                        void'(exp_q.pop_front());
                        if (out_last_a) lasts++;
                        out_cnt++;
                    end
                end
            end
            held      = out_valid_a && !drv_ready;
            held_data = out_data_a;
            if (last_acc) begin
                model(drv_data, drv_approx, 7, e.d7, e.s7);
                model(drv_data, drv_approx, 4, e.d4, e.s4);
                exp_q.push_back(e);
            end
        end
    endtask

    // Lone beat into an idle pipe; returns with its result on the outputs
    task automatic send_iso(input logic [63:0] d, input bit ap);
        drv_valid = 1; drv_data = d; drv_approx = ap; drv_ready = 1;
        cycle();
        drv_valid = 0;
        cycle(); chk("lat_c1", out_valid_a, 1'b0);
        cycle(); chk("lat_c2", out_valid_a, 1'b0);
        cycle(); chk("lat_c3", out_valid_a, 1'b1);
    endtask

    task automatic drain();
        drv_valid = 0; drv_ready = 1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
        cycle();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        drv_valid = 0; drv_rst = 0;
        cycle();
        drv_rst = 1;
        cycle();
    endtask

    initial begin
        logic [63:0] ramp;
        for (int i = 0; i < 8; i++) ramp[i*8 +: 8] = 8'(i);

        drv_rst = 0;
        repeat (2) cycle();
        drv_rst = 1;
        cycle();
        chk("rst_valid", out_valid_a, 1'b0);
        chk("rst_data", out_data_a, 80'd0);
        chk("rst_last", out_last_a, 1'b0);
        chk("rst_sat", out_sat_a, 1'b0);
        chk("rst_data_b", out_data_b, 80'd0);

        send_iso({8{8'd10}}, 0);
        chk("dc_x0", lane(out_data_a, 0), 28);
        chk("dc_x1", lane(out_data_a, 1), 0);
        send_iso(ramp, 0);
        chk("ramp_x0", lane(out_data_a, 0), 10);
        chk("ramp_x1", lane(out_data_a, 1), -7);
        chk("ramp_x3", lane(out_data_a, 3), -1);
        send_iso({8{8'd1}}, 1);
        chk("approx_x0", lane(out_data_a, 0), 2);
        send_iso({8{8'd1}}, 0);
        chk("exact_x0", lane(out_data_a, 0), 3);

        for (int i = 0; i < 6; i++) begin
            drv_valid = 1; drv_data = {8{8'd1}}; drv_approx = (i % 2) == 0;
            cycle();
        end
        drain();

        send_iso({8{8'sd127}}, 0);
        chk("satp_x0", lane(out_data_b, 0), 511);
        chk("satp_flag", out_sat_b, 1'b1);
        send_iso({8{8'h80}}, 0);
        chk("satn_x0", lane(out_data_b, 0), -512);
        chk("satn_flag", out_sat_b, 1'b1);
        send_iso(64'd0, 0);
        chk("zero_flag", out_sat_b, 1'b0);

        // Random stream with a 5-cycle downstream stall
        last_acc = 1;
        for (int i = 0; i < 24; i++) begin
            if (last_acc) begin
                drv_data   = {$urandom, $urandom};
                drv_approx = 1'($urandom_range(0, 1));
            end
            drv_valid = 1;
            drv_ready = !(i >= 8 && i < 13);
            cycle();
        end
        drain();

        pulse_reset();
        lasts = 0;
        for (int i = 0; i < 16; i++) begin
            drv_valid = 1; drv_data = {$urandom, $urandom};
            drv_approx = 1'($urandom_range(0, 1));
            cycle();
        end
        drain();
        chk("block_lasts", lasts, 2);

        for (int i = 0; i < 3; i++) begin
            drv_valid = 1; drv_data = {$urandom, $urandom}; drv_approx = 0;
            cycle();
        end
        pulse_reset();
        chk("flush_valid", out_valid_a, 1'b0);
        repeat (4) cycle();
        lasts = 0;
        for (int i = 0; i < 8; i++) begin
            drv_valid = 1; drv_data = {$urandom, $urandom};
            drv_approx = 1'($urandom_range(0, 1));
            cycle();
        end
        drain();
        chk("post_rst_lasts", lasts, 1);
        chk("post_rst_count", out_cnt, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
